slice_serial_sub16: RTL

- Multi-cycle subtractor; the inverse operation of the team's ripple-carry adder datapath.
- Computes D = A - B - Bin on WIDTH-bit operands, one SLICE-bit slice per clock, LSB slice first.
- Borrow is registered between slices.
- Sits behind a valid/ready producer and feeds a valid/ready consumer; used where area matters more than latency.

---
 rtl/slice_sub_pkg.sv | 15 +
 rtl/slice_sub4.sv | 26 ++
 rtl/slice_serial_sub16.sv | 138 +++++++++++++
 3 files changed

// File: rtl/slice_sub_pkg.sv
// Shared types and default sizing for the slice-serial subtractor.
// NSLICE is the number of clock cycles one subtraction spends in RUN.
package slice_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;
    localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;

endpackage

// File: rtl/slice_sub4.sv
// Combinational SLICE-bit subtract slice: a full-adder ripple with b inverted.
// Borrow is carried internally as its complement (carry = ~borrow).
module slice_sub4 #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             bin_s,
    output logic [SLICE-1:0] d_s,
    output logic             bout_s
);

    logic [SLICE:0]   c;
    logic [SLICE-1:0] bn;

    assign c[0] = ~bin_s;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign bn[i]  = ~b_s[i];
        assign d_s[i] = a_s[i] ^ bn[i] ^ c[i];
        assign c[i+1] = (a_s[i] & bn[i]) | (c[i] & (a_s[i] ^ bn[i]));
    end

    assign bout_s = ~c[SLICE];

endmodule

// File: rtl/slice_serial_sub16.sv
// Multi-cycle subtractor d = a - b - bin, one SLICE-bit slice per clock, LSB first.
// Define SLICE_SUB_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid to capture operands
// RUN   | one slice per cycle at index cnt, borrow registered between slices
// DONE  | out_valid high, d/bout held until out_ready
module slice_serial_sub16
    import slice_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SLICE_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N_SL  = WIDTH / SLICE;
    localparam int CNT_W = (N_SL > 1) ? $clog2(N_SL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SL - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_s, b_s, d_s;
    logic             bout_s;

    assign a_s = a_q[cnt_q*SLICE +: SLICE];
    assign b_s = b_q[cnt_q*SLICE +: SLICE];

    slice_sub4 #(
        .SLICE (SLICE)
    ) u_slice (
        .a_s    (a_s),
        .b_s    (b_s),
        .bin_s  (borrow_q),
        .d_s    (d_s),
        .bout_s (bout_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                d_d[cnt_q*SLICE +: SLICE] = d_s;
                borrow_d = bout_s;
                if (cnt_q == LAST_CNT) begin
                    // counter parks on the last slice rather than wrapping
                    bout_d  = bout_s;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_s[SLICE-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign d         = d_q;
    assign bout      = bout_q;

`ifdef SLICE_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = ovf_q;
`endif

endmodule
